light_manager_multi: RTL and testbench

Multi-channel successor to the single-encoder light manager. One quadrature rotary encoder (a_i/b_i) plus a push button drive CHANNELS independent PWM brightness registers. The button cycles which channel the encoder currently adjusts. Sits between board GPIO (encoder, button) and LED pins; every input is synchronised and debounced internally.

---
 rtl/light_manager_multi.sv | 175 +++++++++++++++++
 tb/tb_light_manager_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/light_manager_multi.sv
// Encoder/button driven multi-channel PWM dimmer with synchronised, debounced inputs.
// Build option: define LIGHT_WRAP_EN for modulo-2^W brightness arithmetic (default saturates).
module light_manager_multi #(
  parameter int unsigned CLOCK_FREQ_MHZ = 100,
  parameter int unsigned DELAY_IN_US    = 1,
  parameter int unsigned PWM_VALUE_SIZE = 8,
  parameter int unsigned BRIGHTNESS_INC = 10,
  parameter int unsigned CHANNELS       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      a_i,
  input  logic                      b_i,
  input  logic                      btn_i,
  output logic [CHANNELS-1:0]       leds_o,
  output logic [CHANNELS-1:0]       sel_o,
  output logic [PWM_VALUE_SIZE-1:0] brightness_o
);

  localparam int unsigned W   = PWM_VALUE_SIZE;
  localparam int unsigned DLY = CLOCK_FREQ_MHZ * DELAY_IN_US;
  localparam int unsigned CW  = $clog2(DLY + 1);
  localparam int unsigned SW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] INC = W'(BRIGHTNESS_INC);

  typedef enum logic [2:0] {IDLE, R1, R2, R3, L1, L2, L3, ERR} state_t;

  // Bit order in the input vectors: {a, b, btn}
  logic [2:0]    sync1, sync2, filt;
  logic [CW-1:0] cnt [3];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {a_i, b_i, btn_i};
      sync2 <= sync1;
    end
  end

  // Filtered bit flips only after DLY consecutive cycles of disagreement
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      filt <= '1;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DLY - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  state_t     state, state_nxt;
  logic       step_up, step_dn;
  logic [1:0] ab;

  assign ab = filt[2:1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    case (state)
      IDLE: case (ab)
              2'b01:   state_nxt = R1;
              2'b10:   state_nxt = L1;
              2'b00:   state_nxt = ERR;
              default: ;
            endcase
      R1:   case (ab)
              2'b00:   state_nxt = R2;
              2'b11:   state_nxt = IDLE;
              2'b10:   state_nxt = ERR;
              default: ;
            endcase
      R2:   case (ab)
              2'b10:   state_nxt = R3;
              2'b01:   state_nxt = R1;
              2'b11:   state_nxt = ERR;
              default: ;
            endcase
      R3:   case (ab)
              2'b11:   begin state_nxt = IDLE; step_up = 1'b1; end
              2'b00:   state_nxt = R2;
              2'b01:   state_nxt = ERR;
              default: ;
            endcase
      L1:   case (ab)
              2'b00:   state_nxt = L2;
              2'b11:   state_nxt = IDLE;
              2'b01:   state_nxt = ERR;
              default: ;
            endcase
      L2:   case (ab)
              2'b01:   state_nxt = L3;
              2'b10:   state_nxt = L1;
              2'b11:   state_nxt = ERR;
              default: ;
            endcase
      L3:   case (ab)
              2'b11:   begin state_nxt = IDLE; step_dn = 1'b1; end
              2'b00:   state_nxt = L2;
              2'b10:   state_nxt = ERR;
              default: ;
            endcase
      default: if (ab == 2'b11) state_nxt = IDLE;
    endcase
  end

  logic [W-1:0]  bright [CHANNELS];
  logic [SW-1:0] ch;
  logic          btn_q, btn_fall;
  logic [W-1:0]  cur, inc_v, dec_v;

  assign btn_fall = btn_q & ~filt[0];
  assign cur      = bright[ch];

  always_comb begin
`ifdef LIGHT_WRAP_EN
    inc_v = cur + INC;
    dec_v = cur - INC;
`else
    inc_v = (cur > MAX - INC) ? MAX : cur + INC;
    dec_v = (cur < INC) ? '0 : cur - INC;
`endif
  end

  // Step writes through the pre-advance channel index when both events coincide
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < CHANNELS; k++) bright[k] <= '0;
      ch    <= '0;
      btn_q <= 1'b1;
    end else begin
      btn_q <= filt[0];
      if (step_up)      bright[ch] <= inc_v;
      else if (step_dn) bright[ch] <= dec_v;
      if (btn_fall) ch <= (ch == SW'(CHANNELS - 1)) ? '0 : ch + SW'(1);
    end
  end

  always_comb begin
    sel_o     = '0;
    sel_o[ch] = 1'b1;
  end

  assign brightness_o = cur;

  logic [W-1:0] pwm_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pwm_cnt <= '0;
      leds_o  <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == MAX - W'(1)) ? '0 : pwm_cnt + W'(1);
      for (int unsigned k = 0; k < CHANNELS; k++) leds_o[k] <= (pwm_cnt < bright[k]);
    end
  end

endmodule

// File: tb/tb_light_manager_multi.sv
// Self-checking bench for light_manager_multi: vector table, randomized ops vs. a
// behavioural brightness/channel model, and hand-written corner sequences.
module tb_light_manager_multi;

  localparam int CH   = 4;
  localparam int MAXV = 255;
  localparam int INC  = 10;

  logic          clk = 1'b0;
  logic          rst_n, a, b, btn;
  logic [CH-1:0] leds, sel;
  logic [7:0]    br;

  light_manager_multi #(
    .CLOCK_FREQ_MHZ(100),
    .DELAY_IN_US(1),
    .PWM_VALUE_SIZE(8),
    .BRIGHTNESS_INC(INC),
    .CHANNELS(CH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .a_i(a),
    .b_i(b),
    .btn_i(btn),
    .leds_o(leds),
    .sel_o(sel),
    .brightness_o(br)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int mb [CH];
  int mch;

  typedef enum {OP_R, OP_L, OP_P, OP_G} op_e;
  typedef struct {
    op_e        op;
    logic [3:0] sel;
    logic [7:0] br;
    bit         pwm;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int idx, input logic v);
    case (idx)
      0:       a = v;
      1:       b = v;
      default: btn = v;
    endcase
  endtask

  // Random chatter shorter than the debounce window, then settle and hold
  task automatic bounce_to(input int idx, input logic v);
    int n;
    n = $urandom_range(10, 60);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_line(idx, 1'($urandom % 2));
    end
    @(negedge clk);
    set_line(idx, v);
    idle(130);
  endtask

  task automatic detent(input bit right);
    int first, second;
    first  = right ? 0 : 1;
    second = right ? 1 : 0;
    bounce_to(first, 1'b0);
    bounce_to(second, 1'b0);
    bounce_to(first, 1'b1);
    bounce_to(second, 1'b1);
  endtask

  function automatic int up_v(input int v);
`ifdef LIGHT_WRAP_EN
    return (v + INC) % 256;
`else
    return (v + INC > MAXV) ? MAXV : v + INC;
`endif
  endfunction

  function automatic int down_v(input int v);
`ifdef LIGHT_WRAP_EN
    return (v - INC + 256) % 256;
`else
    return (v < INC) ? 0 : v - INC;
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < CH; k++) mb[k] = 0;
    mch = 0;
  endtask

  task automatic apply(input op_e op);
    case (op)
      OP_R: begin detent(1'b1); mb[mch] = up_v(mb[mch]); end
      OP_L: begin detent(1'b0); mb[mch] = down_v(mb[mch]); end
      OP_P: begin bounce_to(2, 1'b0); bounce_to(2, 1'b1); mch = (mch + 1) % CH; end
      default: begin
        @(negedge clk); a = 1'b0;
        idle(60);
        a = 1'b1;
        idle(130);
      end
    endcase
  endtask

  task automatic check_model(input string name);
    check({name, "_sel"}, 32'(sel), 32'(1) << mch);
    check({name, "_br"}, 32'(br), 32'(mb[mch]));
  endtask

  task automatic pwm_check(input string name);
    int hi [CH];
    for (int k = 0; k < CH; k++) hi[k] = 0;
    repeat (MAXV) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) hi[k] += int'(leds[k]);
    end
    for (int k = 0; k < CH; k++)
      check($sformatf("%s_duty%0d", name, k), 32'(hi[k]), 32'(mb[k]));
  endtask

  task automatic push(input op_e op, input logic [3:0] s, input logic [7:0] v, input bit p);
    vec_t e;
    e.op = op; e.sel = s; e.br = v; e.pwm = p;
    vecs.push_back(e);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a = 1'b1; b = 1'b1; btn = 1'b1; rst_n = 1'b0;
    model_clear();
    idle(3);
    check("rst_sel", 32'(sel), 32'd1);
    check("rst_br", 32'(br), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    rst_n = 1'b1;
    idle(2000);
    check("idle_sel", 32'(sel), 32'd1);
    check("idle_br", 32'(br), 32'd0);
    pwm_check("idle");

`ifdef LIGHT_WRAP_EN
    push(OP_L, 4'b0001, 8'd246, 1'b0);
    push(OP_R, 4'b0001, 8'd0, 1'b0);
    push(OP_R, 4'b0001, 8'd10, 1'b1);
    for (int i = 2; i <= 25; i++) push(OP_R, 4'b0001, 8'(10 * i), 1'b0);
    push(OP_R, 4'b0001, 8'd4, 1'b0);
    push(OP_L, 4'b0001, 8'd250, 1'b0);
`else
    push(OP_L, 4'b0001, 8'd0, 1'b0);
    push(OP_R, 4'b0001, 8'd10, 1'b1);
    for (int i = 2; i <= 25; i++) push(OP_R, 4'b0001, 8'(10 * i), 1'b0);
    push(OP_R, 4'b0001, 8'd255, 1'b1);
    push(OP_L, 4'b0001, 8'd245, 1'b0);
`endif
    push(OP_P, 4'b0010, 8'd0, 1'b0);
    push(OP_R, 4'b0010, 8'd10, 1'b0);
    push(OP_G, 4'b0010, 8'd10, 1'b0);
    push(OP_P, 4'b0100, 8'd0, 1'b0);
    push(OP_P, 4'b1000, 8'd0, 1'b0);
`ifdef LIGHT_WRAP_EN
    push(OP_P, 4'b0001, 8'd250, 1'b1);
`else
    push(OP_P, 4'b0001, 8'd245, 1'b1);
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].op);
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_br", i), 32'(br), 32'(vecs[i].br));
      if (vecs[i].pwm) pwm_check($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      int r;
      r = $urandom_range(0, 9);
      apply(r < 4 ? OP_R : (r < 7 ? OP_L : OP_P));
      check_model($sformatf("rnd%0d", i));
    end
    pwm_check("rnd");

    // Final B rise and button fall filter through on the same cycle
    bounce_to(0, 1'b0);
    bounce_to(1, 1'b0);
    bounce_to(0, 1'b1);
    @(negedge clk);
    b = 1'b1; btn = 1'b0;
    idle(130);
    mb[mch] = up_v(mb[mch]);
    mch = (mch + 1) % CH;
    check_model("simul");
    pwm_check("simul");
    btn = 1'b1;
    idle(130);

    // Reset while the decoder sits in R2; finishing the rotation must not step
    bounce_to(0, 1'b0);
    bounce_to(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("midrst_sel", 32'(sel), 32'd1);
    check("midrst_br", 32'(br), 32'd0);
    check("midrst_leds", 32'(leds), 32'd0);
    idle(5);
    rst_n = 1'b1;
    idle(200);
    bounce_to(0, 1'b1);
    bounce_to(1, 1'b1);
    check_model("post_rst");
    pwm_check("post_rst");
    apply(OP_R);
    check_model("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
